fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 stall  input  1  decode not ready; hold the delivered instruction.
REQ-005 br_valid  input  1  branch/jump redirect request, one-cycle pulse.
REQ-006 br_target  input  32  redirect address, sampled when br_valid=1.
REQ-007 exc_valid  input  1  exception redirect, one-cycle pulse.
REQ-008 exc_vector  input  32  exception handler address, sampled when exc_valid=1.
REQ-009 inst_ack  input  1  instruction memory response valid.
REQ-010 inst_rdata  input  32  instruction word, valid when inst_ack=1.
REQ-011 ce  output  1  instruction memory enable, equal to inst_req.
REQ-012 inst_req  output  1  fetch request; held high with inst_addr stable until inst_ack.
REQ-013 inst_addr  output  32  fetch address (current pc).
REQ-014 pc  output  32  address of the instruction in flight or held.
REQ-015 if_valid  output  1  if_inst/if_pc hold a valid instruction for decode.
REQ-016 if_pc  output  32  address of if_inst.
REQ-017 if_inst  output  32  fetched instruction word.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, WAIT and HOLD.
- IDLE -> FETCH on the first cycle after rst deasserts.
- FETCH: inst_req=1; -> WAIT.
- WAIT: inst_req=1; on inst_ack, -> HOLD if stall=1, else -> FETCH at pc+4.
- HOLD: inst_req=0; -> FETCH at pc+4 in the cycle after stall=0.
REQ-019 On inst_ack with no redirect in the same cycle, the block SHALL register if_inst=inst_rdata, if_pc=pc and if_valid=1 on the next edge, giving 1-cycle ack-to-decode latency.
REQ-020 When stall=1, if_valid/if_pc/if_inst SHALL hold their values unchanged; with stall=0 and no new ack, if_valid SHALL drop to 0 after one cycle.
REQ-021 Redirect priority SHALL be exc_valid > br_valid > sequential pc+4.
REQ-022 A redirect in any state SHALL load pc with the target, clear if_valid and go to FETCH on the next edge.
REQ-023 If a redirect arrives while a request is outstanding without ack, the block SHALL set a kill flag and wait for that ack, then discard it: no if_valid, and the kill flag clears.
REQ-024 A redirect in the same cycle as inst_ack SHALL discard that response.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 inst_addr SHALL equal pc whenever inst_req=1.
REQ-027 No second request SHALL be issued while one is outstanding.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, ce=0, inst_req=0, if_valid=0, if_pc=0, if_inst=0 and kill=0.
REQ-029 Reset during WAIT SHALL abandon the outstanding request, and a late inst_ack after reset SHALL be ignored until the first new request.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN: when defined, the block SHALL add output fetch_exc (1 bit), which pulses for one cycle if a redirect target has bits [1:0]!=0; that target SHALL NOT be fetched and the FSM SHALL go to HOLD with if_valid=0 until the next redirect. When undefined, there is no fetch_exc port and target bits [1:0] SHALL be forced to 0.

Verification
REQ-031 Reset release, RESET_PC=0, ack every cycle after req, stall=0 -> inst_addr sequence 0,4,8,C; if_pc follows 1 cycle after each ack.
REQ-032 Stall held 3 cycles after ack of pc=8 -> if_inst/if_pc=8 held 3 cycles with inst_req=0; the next request is at C.
REQ-033 br_valid with target 32'h100 while WAIT at pc=10, ack 2 cycles later -> that response is dropped (if_valid=0) and the next request is at 100.
REQ-034 exc_valid (vector 32'h180) and br_valid (target 32'h200) in the same cycle -> the next request is at 180.
REQ-035 pc=32'hFFFF_FFFC acked -> next inst_addr=32'h0000_0000.
REQ-036 With FETCH_ALIGN_CHECK_EN, br_target=32'h102 -> fetch_exc pulses once and no request is issued; rst mid-WAIT -> IDLE and inst_req=0 next cycle.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-side bus bundle between fetch_ctrl (master) and its memory/decode/redirect environment (slave).
// FETCH_ALIGN_CHECK_EN adds the fetch_exc misaligned-redirect pulse.
interface fetch_if;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_valid;
   logic [31:0] exc_vector;
   logic        inst_ack;
   logic [31:0] inst_rdata;
   logic        ce;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fetch_exc;
`endif

   modport master (
`ifdef FETCH_ALIGN_CHECK_EN
      output fetch_exc,
`endif
      input  stall, br_valid, br_target, exc_valid, exc_vector, inst_ack, inst_rdata,
      output ce, inst_req, inst_addr, pc, if_valid, if_pc, if_inst
   );

   modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
      input  fetch_exc,
`endif
      output stall, br_valid, br_target, exc_valid, exc_vector, inst_ack, inst_rdata,
      input  ce, inst_req, inst_addr, pc, if_valid, if_pc, if_inst
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, redirect with late-ack kill, decode hold.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise fetch_exc instead of fetching.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic clk,
   input  logic rst,
   fetch_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      WAIT  = 2'b10,
      HOLD  = 2'b11
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic        kill_r, kill_s;
   logic        req_r, req_s;
   logic        if_valid_r, if_valid_s;
   logic [31:0] if_pc_r, if_pc_s;
   logic [31:0] if_inst_r, if_inst_s;
   logic        align_hold_r, align_hold_s;
   logic        redirect_s;
   logic        misalign_s;
   logic        ack_ok_s;
   logic [31:0] target_raw_s;
   logic [31:0] target_s;

   // Redirect target selection, next-state and next-output decode.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      kill_s       = kill_r;
      if_valid_s   = if_valid_r;
      if_pc_s      = if_pc_r;
      if_inst_s    = if_inst_r;
      align_hold_s = align_hold_r;

      if (bus.exc_valid) begin
         target_raw_s = bus.exc_vector;
      end else if (bus.br_valid) begin
         target_raw_s = bus.br_target;
      end else begin
         target_raw_s = pc_r;
      end
      redirect_s = bus.exc_valid | bus.br_valid;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_s = redirect_s & (target_raw_s[1:0] != 2'b00);
      target_s   = target_raw_s;
`else
      misalign_s = 1'b0;
      target_s   = target_raw_s & 32'hFFFF_FFFC;
`endif
      // An ack only belongs to us while our own request is on the bus.
      ack_ok_s = bus.inst_ack & req_r;

      if (redirect_s) begin
         pc_s       = target_s;
         if_valid_s = 1'b0;
         kill_s     = (kill_r | req_r) & ~bus.inst_ack;
         if (misalign_s) begin
            state_s      = HOLD;
            align_hold_s = 1'b1;
         end else begin
            state_s      = FETCH;
            align_hold_s = 1'b0;
         end
      end else begin
         kill_s = kill_r & ~bus.inst_ack;
         if (ack_ok_s) begin
            if_valid_s = 1'b1;
            if_pc_s    = pc_r;
            if_inst_s  = bus.inst_rdata;
         end else if (bus.stall) begin
            if_valid_s = if_valid_r;
         end else begin
            if_valid_s = 1'b0;
         end

         case (state_r)
            IDLE: begin
               state_s = FETCH;
            end
            FETCH, WAIT: begin
               if (ack_ok_s) begin
                  if (bus.stall) begin
                     state_s = HOLD;
                  end else begin
                     state_s = FETCH;
                     pc_s    = pc_r + 32'd4;
                  end
               end else if (kill_r) begin
                  state_s = FETCH;
               end else begin
                  state_s = WAIT;
               end
            end
            HOLD: begin
               if (align_hold_r) begin
                  state_s = HOLD;
               end else if (!bus.stall) begin
                  state_s = FETCH;
                  pc_s    = pc_r + 32'd4;
               end else begin
                  state_s = HOLD;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end

      // The request stays down while a killed response is still owed to us.
      req_s = ((state_s == FETCH) | (state_s == WAIT)) & ~kill_s;
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         pc_r         <= RESET_PC;
         kill_r       <= 1'b0;
         req_r        <= 1'b0;
         if_valid_r   <= 1'b0;
         if_pc_r      <= 32'h0000_0000;
         if_inst_r    <= 32'h0000_0000;
         align_hold_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         kill_r       <= kill_s;
         req_r        <= req_s;
         if_valid_r   <= if_valid_s;
         if_pc_r      <= if_pc_s;
         if_inst_r    <= if_inst_s;
         align_hold_r <= align_hold_s;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic fetch_exc_r;

   // One-cycle misaligned-redirect pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_exc_r <= 1'b0;
      end else begin
         fetch_exc_r <= misalign_s;
      end
   end

   assign bus.fetch_exc = fetch_exc_r;
`endif

   assign bus.ce        = req_r;
   assign bus.inst_req  = req_r;
   assign bus.inst_addr = pc_r;
   assign bus.pc        = pc_r;
   assign bus.if_valid  = if_valid_r;
   assign bus.if_pc     = if_pc_r;
   assign bus.if_inst   = if_inst_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stall hold, branch kill, priority, wrap, alignment, reset.
module tb_fetch_ctrl;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fetch_if bus ();

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++; if (bus.inst_req !== 1'b0 || bus.ce !== 1'b0) begin n_err++; $display("FAIL reset_req: req=%b ce=%b want 0 0", bus.inst_req, bus.ce); end
      n_cmp++; if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_inst !== 32'h0) begin n_err++; $display("FAIL reset_if: valid=%b pc=%h inst=%h want 0 0 0", bus.if_valid, bus.if_pc, bus.if_inst); end
      n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 00000000", bus.pc); end
      rst = 1'b0;
      tick();
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.ce !== 1'b1 || bus.inst_addr !== 32'h0) begin n_err++; $display("FAIL first_fetch: req=%b ce=%b addr=%h want 1 1 00000000", bus.inst_req, bus.ce, bus.inst_addr); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 2; i++) begin
         logic [31:0] a;
         a = 32'(i) * 32'd4;
         n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== a) begin n_err++; $display("FAIL seq_fetch_addr: req=%b addr=%h want 1 %h", bus.inst_req, bus.inst_addr, a); end
         tick();
         n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== a || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL seq_wait: req=%b addr=%h ifv=%b want 1 %h 0", bus.inst_req, bus.inst_addr, bus.if_valid, a); end
         bus.inst_ack = 1'b1;
         bus.inst_rdata = 32'hA000_0000 | a;
         tick();
         bus.inst_ack = 1'b0;
         n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== a || bus.if_inst !== (32'hA000_0000 | a)) begin n_err++; $display("FAIL seq_deliver: v=%b pc=%h inst=%h want 1 %h %h", bus.if_valid, bus.if_pc, bus.if_inst, a, 32'hA000_0000 | a); end
      end
   endtask

   task automatic test_stall();
      n_cmp++; if (bus.inst_addr !== 32'h8) begin n_err++; $display("FAIL stall_pre_addr: got %h want 00000008", bus.inst_addr); end
      tick();
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hA000_0008;
      bus.stall = 1'b1;
      tick();
      bus.inst_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.if_inst !== 32'hA000_0008 || bus.inst_req !== 1'b0) begin
            n_err++; $display("FAIL stall_hold_%0d: v=%b pc=%h inst=%h req=%b want 1 00000008 a0000008 0", k, bus.if_valid, bus.if_pc, bus.if_inst, bus.inst_req);
         end
         if (k == 2) bus.stall = 1'b0;
         tick();
      end
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hC || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: req=%b addr=%h v=%b want 1 0000000c 0", bus.inst_req, bus.inst_addr, bus.if_valid); end
      tick();
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hA000_000C;
      tick();
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.if_pc !== 32'hC || bus.inst_addr !== 32'h10) begin n_err++; $display("FAIL after_stall: ifpc=%h addr=%h want 0000000c 00000010", bus.if_pc, bus.inst_addr); end
   endtask

   task automatic test_branch_kill();
      tick();
      bus.br_valid = 1'b1;
      bus.br_target = 32'h100;
      tick();
      bus.br_valid = 1'b0;
      n_cmp++; if (bus.inst_req !== 1'b0 || bus.pc !== 32'h100 || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL br_kill_wait: req=%b pc=%h v=%b want 0 00000100 0", bus.inst_req, bus.pc, bus.if_valid); end
      tick();
      n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL br_kill_hold: req=%b want 0", bus.inst_req); end
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hDEAD_BEEF;
      tick();
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.if_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h100) begin n_err++; $display("FAIL br_killed_ack: v=%b req=%b addr=%h want 0 1 00000100", bus.if_valid, bus.inst_req, bus.inst_addr); end
      tick();
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hB000_0100;
      tick();
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_inst !== 32'hB000_0100 || bus.inst_addr !== 32'h104) begin
         n_err++; $display("FAIL br_target_fetch: v=%b pc=%h inst=%h addr=%h want 1 00000100 b0000100 00000104", bus.if_valid, bus.if_pc, bus.if_inst, bus.inst_addr);
      end
   endtask

   task automatic test_priority();
      bus.exc_valid = 1'b1;
      bus.exc_vector = 32'h180;
      bus.br_valid = 1'b1;
      bus.br_target = 32'h200;
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hCCCC_0104;
      tick();
      bus.exc_valid = 1'b0;
      bus.br_valid = 1'b0;
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h180) begin n_err++; $display("FAIL prio_exc: req=%b addr=%h want 1 00000180", bus.inst_req, bus.inst_addr); end
      n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL redirect_same_ack: v=%b want 0", bus.if_valid); end
   endtask

   task automatic test_wrap();
      bus.br_valid = 1'b1;
      bus.br_target = 32'hFFFF_FFFC;
      bus.inst_ack = 1'b1;
      tick();
      bus.br_valid = 1'b0;
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.inst_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre: addr=%h want fffffffc", bus.inst_addr); end
      tick();
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hE000_FFFC;
      tick();
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.inst_addr !== 32'h0 || bus.if_pc !== 32'hFFFF_FFFC || bus.inst_req !== 1'b1) begin n_err++; $display("FAIL wrap: addr=%h ifpc=%h req=%b want 00000000 fffffffc 1", bus.inst_addr, bus.if_pc, bus.inst_req); end
   endtask

`ifdef FETCH_ALIGN_CHECK_EN
   task automatic test_align();
      bus.br_valid = 1'b1;
      bus.br_target = 32'h102;
      bus.inst_ack = 1'b1;
      tick();
      bus.br_valid = 1'b0;
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.fetch_exc !== 1'b1 || bus.inst_req !== 1'b0 || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL align_exc: exc=%b req=%b v=%b want 1 0 0", bus.fetch_exc, bus.inst_req, bus.if_valid); end
      tick();
      n_cmp++; if (bus.fetch_exc !== 1'b0 || bus.inst_req !== 1'b0) begin n_err++; $display("FAIL align_pulse: exc=%b req=%b want 0 0", bus.fetch_exc, bus.inst_req); end
      tick();
      n_cmp++; if (bus.inst_req !== 1'b0) begin n_err++; $display("FAIL align_hold: req=%b want 0", bus.inst_req); end
      bus.br_valid = 1'b1;
      bus.br_target = 32'h200;
      tick();
      bus.br_valid = 1'b0;
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h200) begin n_err++; $display("FAIL align_recover: req=%b addr=%h want 1 00000200", bus.inst_req, bus.inst_addr); end
   endtask
`else
   task automatic test_align();
      bus.br_valid = 1'b1;
      bus.br_target = 32'h102;
      bus.inst_ack = 1'b1;
      tick();
      bus.br_valid = 1'b0;
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h100) begin n_err++; $display("FAIL align_force: req=%b addr=%h want 1 00000100", bus.inst_req, bus.inst_addr); end
   endtask
`endif

   task automatic test_reset_mid_wait();
      tick();
      n_cmp++; if (bus.inst_req !== 1'b1) begin n_err++; $display("FAIL rst_pre_wait: req=%b want 1", bus.inst_req); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.inst_req !== 1'b0 || bus.pc !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0) begin
         n_err++; $display("FAIL rst_mid_wait: req=%b pc=%h v=%b ifpc=%h want 0 00000000 0 00000000", bus.inst_req, bus.pc, bus.if_valid, bus.if_pc);
      end
      bus.inst_ack = 1'b1;
      bus.inst_rdata = 32'hBAD0_BAD0;
      tick();
      bus.inst_ack = 1'b0;
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0 || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL late_ack: req=%b addr=%h v=%b want 1 00000000 0", bus.inst_req, bus.inst_addr, bus.if_valid); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.br_valid = 1'b0;
      bus.br_target = 32'h0;
      bus.exc_valid = 1'b0;
      bus.exc_vector = 32'h0;
      bus.inst_ack = 1'b0;
      bus.inst_rdata = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_kill();
      test_priority();
      test_wrap();
      test_align();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
